branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 65 ++++++
 tb/tb_branch_predictor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter BHT with EX-stage branch resolution and perf counters
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_pc_f,
    output logic             o_pred_taken,
    input  logic             i_Branch,
    input  logic [XLEN-1:0]  i_pc_ex,
    input  logic [2:0]       i_f3,
    input  logic             i_Z,
    input  logic             i_Res,
    input  logic             i_pred_taken,
    output logic             o_DoBranch,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [1:0]    bht [BHT_ENTRIES];
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic [1:0]    cur;
    logic [1:0]    nxt;
    logic          f3_valid;
    logic          cond;
    logic          resolve;
    logic          unused_pc_bits;

    assign rd_idx         = i_pc_f[IW+1:2];
    assign wr_idx         = i_pc_ex[IW+1:2];
    assign unused_pc_bits = ^{i_pc_f[XLEN-1:IW+2], i_pc_f[1:0], i_pc_ex[XLEN-1:IW+2], i_pc_ex[1:0]};

    // f3[2] selects equality (Z) vs compare (Res); f3[0] inverts the sense
    assign f3_valid     = (i_f3 != 3'b010) && (i_f3 != 3'b011);
    assign cond         = (i_f3[2] ? i_Res : i_Z) ^ i_f3[0];
    assign resolve      = i_Branch && f3_valid;
    assign o_DoBranch   = resolve && cond;
    assign o_mispredict = resolve && (o_DoBranch != i_pred_taken);
    assign o_pred_taken = bht[rd_idx][1];

    // saturating step of the counter being resolved
    always_comb begin
        cur = bht[wr_idx];
        nxt = o_DoBranch ? ((cur == 2'b11) ? cur : cur + 2'd1)
                         : ((cur == 2'b00) ? cur : cur - 2'd1);
    end

    // table and counter update; reset discards any coincident resolve
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
            o_branch_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else if (resolve) begin
            bht[wr_idx]   <= nxt;
            o_branch_cnt  <= o_branch_cnt + CNT_W'(1);
            o_mispred_cnt <= o_mispred_cnt + CNT_W'(o_mispredict);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus reset/wrap sequences for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic        br;
    logic [31:0] pc_ex;
    logic [2:0]  f3;
    logic        z;
    logic        res;
    logic        pin;
    logic        do_branch;
    logic        mispredict;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    int n_vec = 0;
    int n_bad = 0;

    branch_predictor #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_pc_f(pc_f), .o_pred_taken(pred_taken),
        .i_Branch(br), .i_pc_ex(pc_ex), .i_f3(f3), .i_Z(z), .i_Res(res),
        .i_pred_taken(pin), .o_DoBranch(do_branch), .o_mispredict(mispredict),
        .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc_f;
        logic        br;
        logic [31:0] pc_ex;
        logic [2:0]  f3;
        logic        z;
        logic        res;
        logic        pin;
        logic        st;
        logic        e_pred;
        logic        e_do;
        logic        e_mis;
        logic [3:0]  e_bc;
        logic [3:0]  e_mc;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(logic r, logic [31:0] pf, logic b, logic [31:0] pe, logic [2:0] f,
                                logic zz, logic rr, logic p, logic st, logic ep, logic ed,
                                logic em, logic [3:0] ebc, logic [3:0] emc);
        vec_t t;
        t.rst = r; t.pc_f = pf; t.br = b; t.pc_ex = pe; t.f3 = f; t.z = zz; t.res = rr; t.pin = p;
        t.st = st; t.e_pred = ep; t.e_do = ed; t.e_mis = em; t.e_bc = ebc; t.e_mc = emc;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [31:0] pf, logic b, logic [31:0] pe, logic [2:0] f,
                         logic zz, logic rr, logic p);
        @(negedge clk);
        rst = r; pc_f = pf; br = b; pc_ex = pe; f3 = f; z = zz; res = rr; pin = p;
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_f = '0; br = 1'b0; pc_ex = '0; f3 = '0; z = 1'b0; res = 1'b0; pin = 1'b0;
        //            rst pc_f     br pc_ex    f3      z  res pin st pred do mis bc mc
        v.push_back(mk(1, 32'h000, 0, 32'h000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 32'h100, 0, 32'h000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 32'h100, 1, 32'h100, 3'b000, 1, 0, 0, 1, 0, 1, 1, 0, 0));
        v.push_back(mk(0, 32'h100, 0, 32'h000, 3'b000, 0, 0, 0, 1, 1, 0, 0, 1, 1));
        v.push_back(mk(1, 32'h100, 0, 32'h000, 3'b000, 0, 0, 0, 1, 1, 0, 0, 1, 1));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 0, 0, 0, 1, 0, 1, 1, 0, 0));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 0, 0, 1, 1, 1, 1, 0, 1, 1));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 0, 0, 1, 1, 1, 1, 0, 2, 1));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 0, 0, 1, 1, 1, 1, 0, 3, 1));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 1, 0, 1, 1, 1, 0, 1, 4, 1));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 1, 0, 1, 1, 1, 0, 1, 5, 2));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 1, 0, 0, 1, 0, 0, 0, 6, 3));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b001, 1, 0, 0, 1, 0, 0, 0, 7, 3));
        v.push_back(mk(0, 32'h200, 0, 32'h000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 8, 3));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b010, 0, 1, 1, 1, 0, 0, 0, 8, 3));
        v.push_back(mk(0, 32'h200, 1, 32'h200, 3'b011, 0, 1, 1, 1, 0, 0, 0, 8, 3));
        v.push_back(mk(0, 32'h200, 0, 32'h000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 8, 3));
        v.push_back(mk(0, 32'h010, 1, 32'h010, 3'b100, 0, 1, 1, 1, 0, 1, 0, 8, 3));
        v.push_back(mk(0, 32'h010, 1, 32'h010, 3'b101, 0, 1, 0, 1, 1, 0, 0, 9, 3));
        v.push_back(mk(0, 32'h010, 1, 32'h010, 3'b110, 0, 0, 1, 1, 0, 0, 1, 10, 3));
        v.push_back(mk(0, 32'h010, 1, 32'h010, 3'b111, 0, 0, 0, 1, 0, 1, 1, 11, 4));
        v.push_back(mk(0, 32'h010, 1, 32'h010, 3'b000, 0, 1, 0, 1, 0, 0, 0, 12, 5));
        v.push_back(mk(0, 32'h010, 0, 32'h010, 3'b000, 1, 0, 1, 1, 0, 0, 0, 13, 5));
        v.push_back(mk(0, 32'h010, 0, 32'h000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 13, 5));
        v.push_back(mk(0, 32'h004, 1, 32'h104, 3'b000, 1, 0, 0, 1, 0, 1, 1, 13, 5));
        v.push_back(mk(0, 32'h004, 0, 32'h000, 3'b000, 0, 0, 0, 1, 1, 0, 0, 14, 6));
        v.push_back(mk(0, 32'h004, 1, 32'h104, 3'b000, 1, 0, 1, 1, 1, 1, 0, 14, 6));
        v.push_back(mk(0, 32'h004, 1, 32'h104, 3'b000, 1, 0, 1, 1, 1, 1, 0, 15, 6));
        v.push_back(mk(0, 32'h004, 0, 32'h000, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 6));
        v.push_back(mk(1, 32'h004, 1, 32'h104, 3'b000, 1, 0, 0, 1, 1, 1, 1, 0, 6));
        v.push_back(mk(0, 32'h004, 0, 32'h000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 32'h004, 1, 32'h104, 3'b000, 1, 0, 1, 1, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 32'h004, 0, 32'h000, 3'b000, 0, 0, 0, 1, 1, 0, 0, 1, 0));

        foreach (v[i]) begin
            drive(v[i].rst, v[i].pc_f, v[i].br, v[i].pc_ex, v[i].f3, v[i].z, v[i].res, v[i].pin);
            check("do_branch", i, 32'(do_branch), 32'(v[i].e_do));
            check("mispredict", i, 32'(mispredict), 32'(v[i].e_mis));
            if (v[i].st) begin
                check("pred_taken", i, 32'(pred_taken), 32'(v[i].e_pred));
                check("branch_cnt", i, 32'(branch_cnt), 32'(v[i].e_bc));
                check("mispred_cnt", i, 32'(mispred_cnt), 32'(v[i].e_mc));
            end
        end

        drive(1, 32'h0, 0, 32'h0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            drive(0, 32'(i * 4), 0, 32'h0, 3'b000, 0, 0, 0);
            check("reset_entry", i, 32'(pred_taken), 32'd0);
        end
        check("reset_bcnt", 0, 32'(branch_cnt), 32'd0);
        check("reset_mcnt", 0, 32'(mispred_cnt), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            drive(0, 32'h0, 1, 32'h020, 3'b000, 1, 0, 0);
            check("wrap_mis", i, 32'(mispredict), 32'd1);
            drive(0, 32'h0, 0, 32'h0, 3'b000, 0, 0, 0);
            check("wrap_bcnt", i, 32'(branch_cnt), 32'(i % 16));
            check("wrap_mcnt", i, 32'(mispred_cnt), 32'(i % 16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
